nand_page_buffer: RTL

Single-page (2048 x 8) staging buffer between the host-side buffer port (BF_*) and the NAND flash controller's byte datapath. The host loads a page before a program command or unloads one after a read command. The flash controller streams the page out (drain, for program) or in (fill, for read) under its own handshake. The block tracks ownership, sequences the address pointers, and produces an XOR checksum of every streamed page.

---
 rtl/nand_page_buffer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/nand_page_buffer.sv
// ---------------------------------------------------------------------------
// nand_page_buffer
//
// Single-page staging RAM between the host buffer port and the NAND flash
// controller's byte datapath. The host loads or unloads the page while the
// block is idle. The controller fills the page (after a flash read) or drains
// it (for a flash program) under its own handshake. A running XOR checksum
// covers every streamed byte.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   BF_sel/BF_we    host select / write enable (honoured only while idle)
//   BF_ad/BF_din    host byte address / write data
//   BF_dout         registered host read data (1-cycle latency)
//   fill_start      pulse: controller starts writing a page into the buffer
//   drain_start     pulse: controller starts reading a page out
//   fl_din(_valid)  fill byte stream, always accepted
//   fl_dout(_valid) drain byte stream, qualified by fl_dout_ready
//   busy            transfer in progress (FILL, PRIME, DRAIN)
//   done            one-cycle pulse at the end of a page transfer
//   err             sticky protocol error, cleared by an accepted start
//   checksum        XOR of the bytes streamed in the current/last page
// ---------------------------------------------------------------------------
module nand_page_buffer #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          BF_sel,
    input  logic          BF_we,
    input  logic [AW-1:0] BF_ad,
    input  logic [DW-1:0] BF_din,
    output logic [DW-1:0] BF_dout,
    input  logic          fill_start,
    input  logic          drain_start,
    input  logic [DW-1:0] fl_din,
    input  logic          fl_din_valid,
    output logic [DW-1:0] fl_dout,
    output logic          fl_dout_valid,
    input  logic          fl_dout_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] checksum
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PRIME,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] checksum_q, checksum_d;
    logic          err_q, err_d;
    logic [DW-1:0] bf_dout_q;
    logic [DW-1:0] fl_dout_q;

    // RAM port controls
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          host_rd_en;
    logic          fl_rd_en;
    logic [AW-1:0] fl_rd_addr;

    logic [DW-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        ram_we     = 1'b0;
        ram_waddr  = BF_ad;
        ram_wdata  = BF_din;
        host_rd_en = 1'b0;
        fl_rd_en   = 1'b0;
        fl_rd_addr = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (BF_sel) begin
                    if (BF_we) begin
                        ram_we = 1'b1;
                    end else begin
                        host_rd_en = 1'b1;
                    end
                end
                if (fill_start && drain_start) begin
                    // Ambiguous request: refuse both and flag it.
                    err_d = 1'b1;
                end else if (fill_start) begin
                    state_d    = S_FILL;
                    wr_ptr_d   = '0;
                    checksum_d = '0;
                    err_d      = 1'b0;
                end else if (drain_start) begin
                    state_d    = S_PRIME;
                    rd_ptr_d   = '0;
                    checksum_d = '0;
                    err_d      = 1'b0;
                end
            end

            S_FILL: begin
                if (fl_din_valid) begin
                    ram_we     = 1'b1;
                    ram_waddr  = wr_ptr_q;
                    ram_wdata  = fl_din;
                    checksum_d = checksum_q ^ fl_din;
                    if (wr_ptr_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end

            S_PRIME: begin
                // Pre-load byte 0 into the output register so DRAIN starts
                // with valid data.
                fl_rd_en   = 1'b1;
                fl_rd_addr = '0;
                state_d    = S_DRAIN;
            end

            S_DRAIN: begin
                if (fl_dout_ready) begin
                    checksum_d = checksum_q ^ fl_dout_q;
                    if (rd_ptr_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        // Look one byte ahead so back-to-back transfers
                        // need no bubble.
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        fl_rd_en   = 1'b1;
                        fl_rd_addr = rd_ptr_q + AW'(1);
                    end
                end else begin
                    fl_rd_en = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Starts and host writes outside IDLE are dropped and flagged.
        if (state_q != S_IDLE) begin
            if (fill_start || drain_start) begin
                err_d = 1'b1;
            end
            if (BF_sel && BF_we) begin
                err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Page RAM: one write port shared by host and fill, two registered
    // read ports (host and drain). Contents survive reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bf_dout_q <= '0;
        end else if (host_rd_en) begin
            bf_dout_q <= mem[BF_ad];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fl_dout_q <= '0;
        end else if (fl_rd_en) begin
            fl_dout_q <= mem[fl_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign BF_dout       = bf_dout_q;
    assign fl_dout       = fl_dout_q;
    assign fl_dout_valid = (state_q == S_DRAIN);
    assign busy          = (state_q == S_FILL) || (state_q == S_PRIME) ||
                           (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign checksum      = checksum_q;

endmodule
